alu_ctrl_seq: RTL and testbench

Registered, handshaked ALU control unit for the pipelined RISC-V core, replacing the single-cycle combinational ALU decoder. It decodes `aluop`/`funct3`/`funct7` into a parametrised-width ALU operation code for R-type, I-type, load/store and all six branch kinds, and flags illegal encodings. It also sequences multi-cycle M-extension operations by holding off new issue until their latency has elapsed. It sits between the main decoder (upstream) and the execute stage (downstream).

---
 rtl/alu_ctrl_pkg.sv | 62 ++++++
 rtl/alu_ctrl_decode.sv | 74 +++++++
 rtl/alu_ctrl_seq.sv | 141 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | alu_ctrl_pkg                                                         |
// | Op codes, aluop/funct7 constants and FSM state type for alu_ctrl_seq |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_ctrl_pkg;

   localparam logic [4:0] OP_AND     = 5'd0;
   localparam logic [4:0] OP_OR      = 5'd1;
   localparam logic [4:0] OP_XOR     = 5'd2;
   localparam logic [4:0] OP_ADD     = 5'd3;
   localparam logic [4:0] OP_SUB     = 5'd4;
   localparam logic [4:0] OP_SLL     = 5'd5;
   localparam logic [4:0] OP_SRL     = 5'd6;
   localparam logic [4:0] OP_SRA     = 5'd7;
   localparam logic [4:0] OP_SLT     = 5'd8;
   localparam logic [4:0] OP_SLTU    = 5'd9;
   localparam logic [4:0] OP_MUL     = 5'd16;
   localparam logic [4:0] OP_MULH    = 5'd17;
   localparam logic [4:0] OP_MULHSU  = 5'd18;
   localparam logic [4:0] OP_MULHU   = 5'd19;
   localparam logic [4:0] OP_DIV     = 5'd20;
   localparam logic [4:0] OP_DIVU    = 5'd21;
   localparam logic [4:0] OP_REM     = 5'd22;
   localparam logic [4:0] OP_REMU    = 5'd23;
   localparam logic [4:0] OP_ILLEGAL = 5'd31;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [6:0] F7_STD  = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;
   localparam logic [6:0] F7_MEXT = 7'h01;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Base integer op selected by funct3 when funct7 carries no modifier.
   function automatic logic [4:0] std_op(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// +----------------------------------------------------------------------+
// | alu_ctrl_decode                                                      |
// | Combinational aluop/funct3/funct7 decode; M ops need ALU_CTRL_MEXT_EN|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic [1:0]     aluop,
   input  logic [2:0]     funct3,
   input  logic [6:0]     funct7,
   output logic [OPW-1:0] code,
   output logic           multicycle,
   output logic           illegal
);

   logic [4:0] w_code;

   always_comb begin
      w_code = OP_ILLEGAL;
      case (aluop)
         ALUOP_MEM: w_code = OP_ADD;
         ALUOP_BR: begin
            case (funct3)
               3'b000, 3'b001: w_code = OP_SUB;
               3'b100, 3'b101: w_code = OP_SLT;
               3'b110, 3'b111: w_code = OP_SLTU;
               default:        w_code = OP_ILLEGAL;
            endcase
         end
         ALUOP_R: begin
            if (funct7 == F7_STD)
               w_code = std_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000)
               w_code = OP_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101)
               w_code = OP_SRA;
`ifdef ALU_CTRL_MEXT_EN
            else if (funct7 == F7_MEXT)
               w_code = {2'b10, funct3};
`endif
            else
               w_code = OP_ILLEGAL;
         end
         default: begin
            // Immediate forms: only the shifts constrain funct7.
            case (funct3)
               3'b000:  w_code = OP_ADD;
               3'b001:  w_code = (funct7 == F7_STD) ? OP_SLL : OP_ILLEGAL;
               3'b101: begin
                  if (funct7 == F7_STD)
                     w_code = OP_SRL;
                  else if (funct7 == F7_ALT)
                     w_code = OP_SRA;
                  else
                     w_code = OP_ILLEGAL;
               end
               default: w_code = std_op(funct3);
            endcase
         end
      endcase
   end

   assign code       = OPW'(w_code);
   assign multicycle = (w_code[4:3] == 2'b10);
   assign illegal    = (w_code == OP_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
// +----------------------------------------------------------------------+
// | alu_ctrl_seq                                                         |
// | Handshaked ALU control register with M-op latency sequencing.        |
// | WAIT FSM/counter exist only when ALU_CTRL_MEXT_EN is defined.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int OPW     = 5,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     aluop,
   input  logic [2:0]     funct3,
   input  logic [6:0]     funct7,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OPW-1:0] alu_ctrl,
   output logic           multicycle,
   output logic           illegal,
   output logic           busy
);

   logic [OPW-1:0] w_dec_code;
   logic           w_dec_mc;
   logic           w_dec_ill;

   logic           r_out_valid;
   logic [OPW-1:0] r_alu_ctrl;
   logic           r_multicycle;
   logic           r_illegal;

   logic           w_busy;
   logic           w_accept;
   logic           w_out_fire;

   alu_ctrl_decode #(
      .OPW(OPW)
   ) u_decode (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7     (funct7),
      .code       (w_dec_code),
      .multicycle (w_dec_mc),
      .illegal    (w_dec_ill)
   );

   // An M op leaving the register starts WAIT on that same edge, so nothing
   // new may be taken behind it.
   assign in_ready   = !flush && !w_busy &&
                       (!r_out_valid || (out_ready && !r_multicycle));
   assign w_accept   = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_alu_ctrl   <= '0;
         r_multicycle <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_alu_ctrl   <= w_dec_code;
         r_multicycle <= w_dec_mc;
         r_illegal    <= w_dec_ill;
      end else if (w_out_fire) begin
         r_out_valid  <= 1'b0;
      end
   end

`ifdef ALU_CTRL_MEXT_EN
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNTW    = $clog2(MAX_LAT + 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CNTW-1:0] r_cnt;
   logic            w_enter_wait;

   assign w_enter_wait = (r_state == ST_IDLE) && w_out_fire && r_multicycle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush)
         w_state_nxt = ST_IDLE;
      else begin
         case (r_state)
            ST_IDLE: if (w_enter_wait) w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_cnt == CNTW'(1)) w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy = (r_state == ST_WAIT);
   end

   // Bit 2 of an M code separates the divide group (20-23) from multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (flush)
         r_cnt <= '0;
      else if (w_enter_wait)
         r_cnt <= r_alu_ctrl[2] ? CNTW'(DIV_LAT) : CNTW'(MUL_LAT);
      else if (r_state == ST_WAIT && r_cnt != '0)
         r_cnt <= r_cnt - CNTW'(1);
   end
`else
   logic [31:0] w_unused_lat;

   assign w_unused_lat = MUL_LAT[31:0] ^ DIV_LAT[31:0];
   assign w_busy       = 1'b0;
`endif

   assign out_valid  = r_out_valid;
   assign alu_ctrl   = r_alu_ctrl;
   assign multicycle = r_multicycle;
   assign illegal    = r_illegal;
   assign busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// +----------------------------------------------------------------------+
// | tb_alu_ctrl_seq                                                      |
// | Directed + random bench for alu_ctrl_seq against a behavioural model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_ctrl_seq;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 33;
`ifdef ALU_CTRL_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [1:0] aluop     = 2'b00;
   logic [2:0] funct3    = 3'b000;
   logic [6:0] funct7    = 7'h00;
   logic       flush     = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [4:0] alu_ctrl;
   logic       multicycle;
   logic       illegal;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state: the output slot and remaining WAIT cycles.
   bit m_valid = 1'b0;
   int m_code  = 0;
   bit m_wait_mc;
   int m_wait  = 0;

   alu_ctrl_seq #(
      .OPW     (5),
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7     (funct7),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_ctrl   (alu_ctrl),
      .multicycle (multicycle),
      .illegal    (illegal),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ref_code(input int a, input int f3, input int f7);
      int base [8];
      base = '{3, 5, 8, 9, 2, 6, 1, 0};
      if (a == 0) return 3;
      if (a == 1) begin
         if (f3 == 2 || f3 == 3) return 31;
         if (f3 < 2) return 4;
         return (f3 < 6) ? 8 : 9;
      end
      if (a == 2) begin
         if (f7 == 0) return base[f3];
         if (f7 == 32 && f3 == 0) return 4;
         if (f7 == 32 && f3 == 5) return 7;
         if (f7 == 1 && MEXT) return 16 + f3;
         return 31;
      end
      if (f3 == 0) return 3;
      if (f3 == 1) return (f7 == 0) ? 5 : 31;
      if (f3 == 5) return (f7 == 0) ? 6 : ((f7 == 32) ? 7 : 31);
      return base[f3];
   endfunction

   function automatic bit is_m(input int c);
      return c >= 16 && c <= 23;
   endfunction

   // Compare process: checks every cycle, then advances the model over the edge.
   always @(negedge clk) begin
      bit exp_rdy, fire, acc;
      #2;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_code  = 0;
         m_wait  = 0;
      end
      m_wait_mc = is_m(m_code);
      exp_rdy = !flush && m_wait == 0 && (!m_valid || (out_ready && !m_wait_mc));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("busy", int'(busy), (m_wait > 0) ? 1 : 0);
      if (m_valid) begin
         chk("alu_ctrl", int'(alu_ctrl), m_code);
         chk("illegal", int'(illegal), (m_code == 31) ? 1 : 0);
         chk("multicycle", int'(multicycle), int'(m_wait_mc));
      end
      if (rst_n) begin
         fire = m_valid && out_ready;
         acc  = in_valid && exp_rdy;
         if (flush) begin
            m_valid = 1'b0;
            m_wait  = 0;
         end else begin
            if (m_wait > 0)
               m_wait--;
            else if (fire && m_wait_mc)
               m_wait = (m_code >= 20) ? DIV_LAT : MUL_LAT;
            if (acc) begin
               m_valid = 1'b1;
               m_code  = ref_code(int'(aluop), int'(funct3), int'(funct7));
            end else if (fire) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   // Drives one cycle's inputs; returns 3 time units after the falling edge.
   task automatic setin(input logic v, input logic [1:0] a, input logic [2:0] f3,
                        input logic [6:0] f7, input logic ordy, input logic fl,
                        input logic rs);
      @(negedge clk);
      #1;
      rst_n     = rs;
      in_valid  = v;
      aluop     = a;
      funct3    = f3;
      funct7    = f7;
      out_ready = ordy;
      flush     = fl;
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic count_busy(input int window, output int n);
      n = 0;
      for (int i = 0; i < window; i++) begin
         setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
         if (busy) n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nb;
      logic [6:0] f7r;

      chk("pin_br_beq", ref_code(1, 0, 0), 4);
      chk("pin_r_sra", ref_code(2, 5, 32), 7);
      chk("pin_i_srai_bad", ref_code(3, 5, 1), 31);
      chk("pin_i_andi", ref_code(3, 7, 5), 0);

      // Reset values
      repeat (3) @(negedge clk);
      #3;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_alu_ctrl", int'(alu_ctrl), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_multicycle", int'(multicycle), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      // Back-to-back load/store then branch
      setin(1'b1, 2'b00, 3'b111, 7'h55, 1'b1, 1'b0, 1'b1);
      chk("b2b_in_ready", int'(in_ready), 1);
      setin(1'b1, 2'b01, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("b2b_add", int'(alu_ctrl), 3);
      chk("b2b_add_ill", int'(illegal), 0);
      setin(1'b1, 2'b10, 3'b101, 7'h20, 1'b1, 1'b0, 1'b1);
      chk("b2b_sub", int'(alu_ctrl), 4);
      chk("b2b_sub_valid", int'(out_valid), 1);

      // Alternate-funct7 and illegal encodings
      setin(1'b1, 2'b10, 3'b110, 7'h20, 1'b1, 1'b0, 1'b1);
      chk("sra", int'(alu_ctrl), 7);
      setin(1'b1, 2'b01, 3'b010, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("r_alt_bad", int'(alu_ctrl), 31);
      chk("r_alt_bad_ill", int'(illegal), 1);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("br_bad", int'(alu_ctrl), 31);
      chk("br_bad_ill", int'(illegal), 1);
      chk("br_bad_busy", int'(busy), 0);
      idle(1);

      // Stall: out_ready low for 3 cycles with an XORI waiting
      setin(1'b1, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         setin(1'b1, 2'b11, 3'b100, 7'h00, 1'b0, 1'b0, 1'b1);
         chk("stall_hold", int'(alu_ctrl), 3);
         chk("stall_in_ready", int'(in_ready), 0);
      end
      setin(1'b1, 2'b11, 3'b100, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("stall_release_rdy", int'(in_ready), 1);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("stall_second", int'(alu_ctrl), 2);
      chk("stall_second_v", int'(out_valid), 1);
      idle(1);

      // Flush drops an input offered in the same cycle
      setin(1'b1, 2'b00, 3'b000, 7'h00, 1'b1, 1'b1, 1'b1);
      chk("flush_in_ready", int'(in_ready), 0);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
      chk("flush_drop", int'(out_valid), 0);

      // Asynchronous reset during a stall
      setin(1'b1, 2'b10, 3'b100, 7'h00, 1'b0, 1'b0, 1'b1);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1);
      chk("stall_pre_rst", int'(out_valid), 1);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
      chk("stall_rst_valid", int'(out_valid), 0);
      chk("stall_rst_code", int'(alu_ctrl), 0);
      idle(1);

      // M-extension sequencing
      setin(1'b1, 2'b10, 3'b000, 7'h01, 1'b1, 1'b0, 1'b1);
      setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
      if (MEXT) begin
         chk("mul_code", int'(alu_ctrl), 16);
         chk("mul_mc", int'(multicycle), 1);
         chk("mul_in_ready", int'(in_ready), 0);
         count_busy(6, nb);
         chk("mul_busy_cycles", nb, MUL_LAT);
         chk("mul_after_rdy", int'(in_ready), 1);

         setin(1'b1, 2'b10, 3'b101, 7'h01, 1'b1, 1'b0, 1'b1);
         setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
         chk("divu_code", int'(alu_ctrl), 21);
         count_busy(40, nb);
         chk("divu_busy_cycles", nb, DIV_LAT);

         // Flush when the counter reads 10
         setin(1'b1, 2'b10, 3'b100, 7'h01, 1'b1, 1'b0, 1'b1);
         setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
         idle(DIV_LAT - 10);
         setin(1'b1, 2'b00, 3'b000, 7'h00, 1'b1, 1'b1, 1'b1);
         chk("wflush_busy_before", int'(busy), 1);
         chk("wflush_in_ready", int'(in_ready), 0);
         setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b1);
         chk("wflush_busy", int'(busy), 0);
         chk("wflush_valid", int'(out_valid), 0);
         chk("wflush_rdy", int'(in_ready), 1);

         // Reset in the middle of WAIT
         setin(1'b1, 2'b10, 3'b111, 7'h01, 1'b1, 1'b0, 1'b1);
         idle(5);
         chk("wrst_busy_before", int'(busy), 1);
         setin(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0);
         chk("wrst_busy", int'(busy), 0);
         chk("wrst_rdy", int'(in_ready), 1);
      end else begin
         chk("nomext_code", int'(alu_ctrl), 31);
         chk("nomext_ill", int'(illegal), 1);
         chk("nomext_mc", int'(multicycle), 0);
         count_busy(6, nb);
         chk("nomext_busy_cycles", nb, 0);
      end
      idle(2);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0:       f7r = 7'h00;
            1:       f7r = 7'h20;
            2:       f7r = 7'h01;
            default: f7r = 7'($urandom);
         endcase
         setin(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
               2'($urandom), 3'($urandom), f7r,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0);
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
